// File: rtl/wb_regfile_sb_if.sv
// Writeback / decode-side bundle of the integer register file with RAW scoreboard.
// The pipeline side is the master; the register file is the slave.
interface wb_regfile_sb_if #(
  parameter int XLEN = 32
);
  logic            wb_valid;
  logic            wb_memtoreg;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_read_data;
  logic [XLEN-1:0] wb_alu_result;

  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_used;
  logic            rs2_used;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  logic            issue_valid;
  logic [4:0]      issue_rd;

  logic            hazard_stall;
  logic            sb_overflow;
  logic            sb_underflow;

  modport master (
    output wb_valid, wb_memtoreg, wb_rd, wb_read_data, wb_alu_result,
    output rs1_addr, rs2_addr, rs1_used, rs2_used,
    output issue_valid, issue_rd,
    input  rs1_data, rs2_data, hazard_stall, sb_overflow, sb_underflow
  );

  modport slave (
    input  wb_valid, wb_memtoreg, wb_rd, wb_read_data, wb_alu_result,
    input  rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  issue_valid, issue_rd,
    output rs1_data, rs2_data, hazard_stall, sb_overflow, sb_underflow
  );
endinterface

// File: rtl/wb_regfile_sb.sv
// Writeback stage register file: WB data select, 32x32 regs with write-through
// read ports, and a 2-bit per-register pending-write scoreboard for RAW stalls.
module wb_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           reset,
  wb_regfile_sb_if.slave bus
);
  localparam int AW = 5;

  logic [XLEN-1:0]  wb_data;
  logic             wb_wr;
  logic [XLEN-1:0]  regs [NREGS];
  logic [1:0]       pend [NREGS];
  logic [NREGS-1:0] inc_vec;
  logic [NREGS-1:0] dec_vec;
  logic [NREGS-1:0] busy_vec;
  logic             ovf_set;
  logic             unf_set;
  logic             ovf_q;
  logic             unf_q;

  assign wb_data = bus.wb_memtoreg ? bus.wb_read_data : bus.wb_alu_result;
  assign wb_wr   = bus.wb_valid && (bus.wb_rd != '0);

  // regs[0] is only ever reset; address 0 is forced to zero on the read side anyway
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wb_wr) begin
      regs[bus.wb_rd] <= wb_data;
    end
  end

  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    if (bus.rs1_addr == '0)
      bus.rs1_data = '0;
    else if (bus.wb_valid && (bus.wb_rd == bus.rs1_addr))
      bus.rs1_data = wb_data;
  end

  always_comb begin
    bus.rs2_data = regs[bus.rs2_addr];
    if (bus.rs2_addr == '0)
      bus.rs2_data = '0;
    else if (bus.wb_valid && (bus.wb_rd == bus.rs2_addr))
      bus.rs2_data = wb_data;
  end

  // Busy uses pend minus this cycle's retirement; a retirement against an
  // empty counter (underflow) is treated as not busy rather than wrapping.
  always_comb begin
    inc_vec  = '0;
    dec_vec  = '0;
    busy_vec = '0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      inc_vec[r]  = bus.issue_valid && (bus.issue_rd == AW'(r));
      dec_vec[r]  = bus.wb_valid && (bus.wb_rd == AW'(r));
      busy_vec[r] = dec_vec[r] ? (pend[r] > 2'd1) : (pend[r] != 2'd0);
      if (inc_vec[r] && !dec_vec[r] && (pend[r] == 2'd3)) ovf_set = 1'b1;
      if (dec_vec[r] && !inc_vec[r] && (pend[r] == 2'd0)) unf_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) pend[r] <= 2'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (inc_vec[r] && !dec_vec[r] && (pend[r] != 2'd3))
          pend[r] <= pend[r] + 2'd1;
        else if (dec_vec[r] && !inc_vec[r] && (pend[r] != 2'd0))
          pend[r] <= pend[r] - 2'd1;
      end
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  assign bus.hazard_stall = (bus.rs1_used && busy_vec[bus.rs1_addr]) ||
                            (bus.rs2_used && busy_vec[bus.rs2_addr]);
  assign bus.sb_overflow  = ovf_q;
  assign bus.sb_underflow = unf_q;

endmodule

// File: doc/wb_regfile_sb.md
# wb_regfile_sb

Writeback-side consumer of the MEM/WB pipeline register. It selects the writeback value (load data or ALU result), writes the 32×32 integer register file, and serves two combinational read ports to decode with write-through bypass. A per-register pending-write scoreboard gives decode a RAW stall signal for destinations issued but not yet written back.

## Interface

- XLEN, 32, data width of the registers and ports
- NREGS, 32, number of architectural registers; fixed, addresses are 5 bits
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  writeback instruction present in WB this cycle
- wb_memtoreg  in  1  1 selects wb_read_data, 0 selects wb_alu_result
- wb_rd  in  5  destination register of the WB instruction
- wb_read_data  in  XLEN  load data from MEM/WB
- wb_alu_result  in  XLEN  ALU result from MEM/WB
- rs1_addr, rs2_addr  in  5 each  decode read addresses
- rs1_used, rs2_used  in  1 each  the decoded instruction actually reads rs1/rs2
- rs1_data, rs2_data  out  XLEN each  read data, combinational
- issue_valid  in  1  an instruction that writes issue_rd leaves decode this cycle
- issue_rd  in  5  destination of the issuing instruction
- hazard_stall  out  1  combinational RAW stall request to decode
- sb_overflow  out  1  sticky error: issue to a register already at 3 pending writes
- sb_underflow  out  1  sticky error: writeback to a register with 0 pending writes

## Operation

- Writeback value: wb_data = wb_memtoreg ? wb_read_data : wb_alu_result.
- Write: at the rising edge, if !reset && wb_valid && wb_rd != 0, regs[wb_rd] <= wb_data. Writes to x0 are discarded.
- Read, per port: addr == 0 → 0; else wb_valid && wb_rd == addr → wb_data (bypass); else regs[addr].
- Scoreboard: a 2-bit counter pend[r] for r = 1..31. pend[0] is constant 0.
  - inc = issue_valid && issue_rd == r && r != 0; dec = wb_valid && wb_rd == r && r != 0.
  - inc && !dec: pend += 1. If pend == 3, it holds at 3 and sb_overflow is set.
  - dec && !inc: pend -= 1. If pend == 0, it holds at 0 and sb_underflow is set. The register write is still performed.
  - inc && dec: pend is unchanged, no flag is set.
- Effective busy: eff[r] = pend[r] − dec(r), computed this cycle. busy(r) = r != 0 && eff[r] != 0.
- hazard_stall = (rs1_used && busy(rs1_addr)) || (rs2_used && busy(rs2_addr)).
- A WB retiring the last pending write to a source register removes the stall in the same cycle, because the bypass supplies the value.
- issue_valid must only be asserted for instructions guaranteed to reach WB. The block does no squash or flush handling.
- issue_valid is taken as given. The block does not gate it with hazard_stall.

## Timing

- Reset (synchronous): all regs = 0, all pend = 0, sb_overflow = sb_underflow = 0.
  - The cycle after reset: rs1_data/rs2_data = 0 for every address (absent WB bypass), and hazard_stall = 0.
- While reset is high, writes and counter updates are suppressed. Bypass on the read ports still follows the inputs.
- Reset mid-operation discards all pending counts. In-flight WB writes after reset will raise sb_underflow unless the pipeline is reset as well; pipeline registers are reset on the same signal.
- Write latency: a value written at edge N is visible from regs at cycle N+1. It is visible via bypass in the same cycle it is presented.
- Scoreboard latency: an issue at edge N makes the register busy from cycle N+1.
- Error flags assert the cycle after the offending edge and clear only on reset.

## Test plan

- Reset, then sweep rs1_addr/rs2_addr over 0..31 with wb_valid = 0 → all data 0, hazard_stall = 0, both flags 0.
- WB wb_rd = 5, memtoreg = 0, alu = 0x0000_1234, read_data = 0xDEAD_BEEF, with rs1_addr = 5 in the same cycle → rs1_data = 0x1234 via bypass. Next cycle with wb_valid = 0 → rs1_data = 0x1234. Repeat with memtoreg = 1 → 0xDEAD_BEEF.
- WB wb_rd = 0 with data 0xFFFF_FFFF → rs1_addr = 0 reads 0 in the same cycle and afterwards. Issue to rd 0 → hazard_stall never asserts.
- Issue rd 7. Next cycle rs1_addr = 7, rs1_used = 1 → hazard_stall = 1. With rs1_used = 0 → 0. Then WB rd 7 = 0x55 in the same cycle as the read → hazard_stall = 0 and rs1_data = 0x55.
- Two issues to rd 9 in cycles 1 and 2, one WB to rd 9 → still busy, stall = 1. Second WB → stall = 0.
- Issue and WB to rd 3 in the same cycle → pend unchanged.
- Four issues to rd 12 with no WB → sb_overflow = 1 and pend[12] holds at 3.
- WB rd 4 with pend = 0 → sb_underflow = 1 and regs[4] is still written.
- Assert reset → both flags and all pend clear, and regs read 0.
